// File: rtl/sm_cpu_dispatcher.sv
// Feeds 16-bit samples from a small FIFO to the add5/mul3/sub7 engine one at a
// time, returns each 32-bit result on a valid/ready stream, and flags an engine
// that never raises done.
module sm_cpu_dispatcher #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        eng_start,
    output logic [15:0] eng_x,
    input  logic [31:0] eng_y,
    input  logic        eng_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        err_timeout,
    output logic [15:0] result_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_ISSUE  = 2'd1,
        D_WAIT   = 2'd2,
        D_RESULT = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q;
    logic            eng_start_q;
    logic [15:0]     eng_x_q, eng_x_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            busy_q;
    logic            err_q, err_d;
    logic [15:0]     result_cnt_q, result_cnt_d;
    logic [TW-1:0]   wdog_q, wdog_d;

    logic            push, pop, capture;
    logic            out_xfer, out_free, fifo_empty;

    assign push       = in_valid && !full_q;
    assign out_xfer   = out_valid_q && out_ready;
    assign out_free   = !out_valid_q || out_ready;
    assign fifo_empty = (count_q == '0);

    // Sequencing FSM: issue, wait for done or watchdog, park the result
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        capture     = 1'b0;
        eng_x_d     = eng_x_q;
        out_valid_d = out_valid_q && !out_xfer;
        out_data_d  = out_data_q;
        err_d       = err_q;
        wdog_d      = wdog_q;
        case (state_q)
            D_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    eng_x_d = mem_q[rd_ptr_q];
                    state_d = D_ISSUE;
                end
            end
            D_ISSUE: begin
                wdog_d  = '0;
                state_d = D_WAIT;
            end
            D_WAIT: begin
                if (eng_done) begin
                    if (out_free) begin
                        capture = 1'b1;
                    end else begin
                        state_d = D_RESULT;
                    end
                end else if (wdog_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = D_IDLE;
                end else begin
                    wdog_d = wdog_q + TW'(1);
                end
            end
            D_RESULT: begin
                if (out_free) begin
                    capture = 1'b1;
                end
            end
            default: state_d = D_IDLE;
        endcase
        // A captured result frees the engine; chain straight into the next sample
        if (capture) begin
            out_data_d  = eng_y;
            out_valid_d = 1'b1;
            if (!fifo_empty) begin
                pop     = 1'b1;
                eng_x_d = mem_q[rd_ptr_q];
                state_d = D_ISSUE;
            end else begin
                state_d = D_IDLE;
            end
        end
    end

    assign count_d      = count_q + CW'(push) - CW'(pop);
    assign result_cnt_d = result_cnt_q + 16'(out_xfer);

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= D_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_x_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            result_cnt_q <= '0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_q + AW'(push);
            rd_ptr_q     <= rd_ptr_q + AW'(pop);
            count_q      <= count_d;
            full_q       <= (count_d == CW'(DEPTH));
            eng_start_q  <= (state_d == D_ISSUE);
            eng_x_q      <= eng_x_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            busy_q       <= (state_d != D_IDLE) || (count_d != '0);
            err_q        <= err_d;
            result_cnt_q <= result_cnt_d;
            wdog_q       <= wdog_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready    = !full_q;
    assign eng_start   = eng_start_q;
    assign eng_x       = eng_x_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;
    assign result_cnt  = result_cnt_q;

endmodule

// File: tb/tb_sm_cpu_dispatcher.sv
// Bench for sm_cpu_dispatcher: engine stub computing 3x+8 with 4-cycle done,
// in-order scoreboard on the output stream, directed and random phases.
module tb_sm_cpu_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        eng_start;
    logic [15:0] eng_x;
    logic [31:0] eng_y = '0;
    logic        eng_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;
    logic        err_timeout;
    logic [15:0] result_cnt;

    sm_cpu_dispatcher #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_done(eng_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err_timeout(err_timeout), .result_cnt(result_cnt)
    );

    always #5 clk = ~clk;

    // Engine stub: y = ((x+5)*3)-7, done four cycles after the sampled start
    int          pend = 0;
    logic [31:0] eng_res = '0;
    bit          hang = 1'b0;
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0 && !hang) begin
                    eng_done = 1'b1;
                    eng_y    = eng_res;
                end
            end
            if (eng_start) begin
                pend    = 4;
                eng_res = 32'((int'($signed(eng_x)) + 5) * 3 - 7);
            end
        end
    end

    logic [31:0] exp_q[$];
    int          starts_q[$];
    int          exp_cnt = 0;
    int          cycle = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // One clock: record handshakes before the edge, check after it
    task automatic cyc();
        logic        ai, ao, hd;
        logic [31:0] od;
        logic [15:0] id;
        ai = in_valid && in_ready;
        ao = out_valid && out_ready;
        hd = out_valid && !out_ready;
        od = out_data;
        id = in_data;
        @(posedge clk);
        #1;
        cycle++;
        if (eng_start) starts_q.push_back(cycle);
        if (ai && !hang) exp_q.push_back(32'((int'($signed(id)) + 5) * 3 - 7));
        if (ao) begin
            if (exp_q.size() > 0) chk("out_data", od, exp_q.pop_front());
            else chk("out_extra", 32'(exp_q.size()), 32'd1);
            exp_cnt++;
        end
        chk("result_cnt", 32'(result_cnt), 32'(16'(exp_cnt)));
        if (hd && rst_n) begin
            chk1("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, od);
        end
    endtask

    task automatic check_reset(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        chk1({tag, "_eng_start"}, eng_start, 1'b0);
        chk({tag, "_eng_x"}, 32'(eng_x), 32'd0);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_err"}, err_timeout, 1'b0);
        chk({tag, "_cnt"}, 32'(result_cnt), 32'd0);
    endtask

    task automatic drain(input int budget);
        int lim;
        lim = cycle + budget;
        while (exp_q.size() > 0 && cycle < lim) cyc();
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int          c;
        int          idx;
        int          off;
        logic [15:0] v2[8];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;
        cyc();
        check_reset("rel");

        // 1: single sample 3 -> 17
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'd3;
        c = cycle;
        cyc();
        in_valid = 1'b0;
        while (cycle <= c + 8) begin
            chk1("t1_start", eng_start, cycle == c + 2);
            chk1("t1_valid", out_valid, cycle == c + 7);
            if (cycle == c + 7) chk("t1_data", out_data, 32'd17);
            cyc();
        end
        chk("t1_cnt", 32'(result_cnt), 32'd1);

        // 2: signed extremes back-to-back, FIFO fills, 5-cycle issue spacing
        v2[0] = 16'hFFFE; v2[1] = 16'h0000; v2[2] = 16'h7FFF; v2[3] = 16'h8000;
        for (int i = 4; i < 8; i++) v2[i] = 16'($urandom);
        starts_q.delete();
        idx = 0;
        c = cycle;
        while (idx < 8 && cycle < c + 100) begin
            in_valid = 1'b1;
            in_data  = v2[idx];
            off = cycle - c;
            if (off <= 4) chk1("t2_ready_hi", in_ready, 1'b1);
            if (off == 5 || off == 6) chk1("t2_ready_full", in_ready, 1'b0);
            if (off == 7) chk1("t2_ready_again", in_ready, 1'b1);
            if (in_ready) idx++;
            cyc();
        end
        in_valid = 1'b0;
        drain(200);
        chk("t2_nstarts", 32'(starts_q.size()), 32'd8);
        for (int i = 1; i < starts_q.size(); i++)
            chk("t2_gap", 32'(starts_q[i] - starts_q[i-1]), 32'd5);

        // 3: backpressure holds 11, second result parks, no third start
        out_ready = 1'b0;
        starts_q.delete();
        c = cycle;
        in_valid = 1'b1; in_data = 16'd1; cyc();
        in_data = 16'd2; cyc();
        in_data = 16'd5; cyc();
        in_valid = 1'b0;
        while (cycle < c + 20) begin
            if (cycle >= c + 7) begin
                chk1("t3_valid", out_valid, 1'b1);
                chk("t3_data", out_data, 32'd11);
                chk1("t3_busy", busy, 1'b1);
            end
            cyc();
        end
        chk("t3_nstarts", 32'(starts_q.size()), 32'd2);
        if (starts_q.size() >= 2) chk("t3_gap", 32'(starts_q[1] - starts_q[0]), 32'd5);
        out_ready = 1'b1;
        cyc();
        chk1("t3_valid2", out_valid, 1'b1);
        chk("t3_data2", out_data, 32'd14);
        drain(50);

        // 4: watchdog on a hung engine, then normal sample 4 -> 20
        hang = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd9;
        c = cycle;
        cyc();
        in_valid = 1'b0;
        while (cycle <= c + 18) begin
            chk1("t4_err", err_timeout, cycle >= c + 18);
            chk1("t4_no_out", out_valid, 1'b0);
            cyc();
        end
        hang = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'd4;
        cyc();
        in_valid = 1'b0;
        c = cycle;
        while (!out_valid && cycle < c + 20) cyc();
        chk("t4_data", out_data, 32'd20);
        drain(20);
        chk1("t4_sticky", err_timeout, 1'b1);

        // 5: reset while waiting with two samples queued
        in_valid = 1'b1;
        in_data = 16'd7; cyc();
        in_data = 16'd8; cyc();
        in_data = 16'd10; cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        #1;
        check_reset("t5_in");
        cyc();
        cyc();
        rst_n = 1'b1;
        check_reset("t5_rel");
        out_ready = 1'b1;
        starts_q.delete();
        repeat (10) cyc();
        chk("t5_no_start", 32'(starts_q.size()), 32'd0);
        chk1("t5_idle", busy, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'hFFF0;
        cyc();
        in_valid = 1'b0;
        drain(30);

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(300);
        repeat (3) cyc();
        chk1("final_idle", busy, 1'b0);
        chk1("final_err", err_timeout, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
